// File: rtl/fft_stage_ctrl.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT: validates the runtime config,
// then issues read, twiddle and delayed write addresses. Define FFT_CTRL_STALL_EN to add the stall input.
module fft_stage_ctrl #(
    parameter int ADDR_W = 12,
    parameter int STG_W  = 4,
    parameter int BF_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [STG_W-1:0]  stage_number,
    input  logic [ADDR_W-1:0] max_point_fft,
`ifdef FFT_CTRL_STALL_EN
    input  logic              stall,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [STG_W-1:0]  cur_stage,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic [ADDR_W-2:0] tw_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_a,
    output logic [ADDR_W-1:0] wr_addr_b
);

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, DRAIN, FIN} state_t;

    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
    localparam logic [ADDR_W:0]   ONE_W      = (ADDR_W+1)'(1);
    localparam logic [STG_W-1:0]  STG_ONE    = STG_W'(1);
    localparam logic [STG_W:0]    ADDR_W_S   = (STG_W+1)'(ADDR_W);
    localparam logic [2:0]        DRAIN_LAST = 3'(BF_LAT - 1);

    state_t              state_q;
    logic [STG_W-1:0]    s_tot_q, s_q, s_d;
    logic [ADDR_W-1:0]   n_q, k_q, k_d;
    logic [2:0]          dcnt_q;
    logic                rd_en_q, busy_q, done_q, err_q;
    logic [ADDR_W-1:0]   rda_q, rdb_q, rda_d, rdb_d;
    logic [ADDR_W-2:0]   tw_q, tw_d;
    logic                hold, rd_fire, cfg_ok;
    logic [ADDR_W-1:0]   last_k;

    logic                vld_p [BF_LAT];
    logic [ADDR_W-1:0]   wra_p [BF_LAT];
    logic [ADDR_W-1:0]   wrb_p [BF_LAT];

    // Upper input of butterfly k in stage s: group base (g<<(s+1)) plus offset j inside the group.
    function automatic logic [ADDR_W-1:0] bf_addr_a(input logic [STG_W-1:0] s,
                                                    input logic [ADDR_W-1:0] k);
        logic [ADDR_W-1:0] mask;
        mask = (ONE << s) - ONE;
        return ((k >> s) << (s + STG_ONE)) | (k & mask);
    endfunction

    function automatic logic [ADDR_W-2:0] bf_tw(input logic [STG_W-1:0]  s_tot,
                                                input logic [STG_W-1:0]  s,
                                                input logic [ADDR_W-1:0] k);
        logic [ADDR_W-1:0] j;
        j = k & ((ONE << s) - ONE);
        return (ADDR_W-1)'(j << (s_tot - s - STG_ONE));
    endfunction

`ifdef FFT_CTRL_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign rd_fire = rd_en_q & ~hold;
    assign cfg_ok  = (s_tot_q != '0) && ({1'b0, s_tot_q} <= ADDR_W_S) &&
                     ({1'b0, n_q} == (ONE_W << s_tot_q));
    assign last_k  = (n_q >> 1) - ONE;

    // Butterfly that becomes current if the FSM issues on this edge.
    always_comb begin
        s_d = s_q;
        k_d = k_q;
        case (state_q)
            CHECK: begin
                s_d = '0;
                k_d = '0;
            end
            ISSUE: k_d = k_q + ONE;
            DRAIN: begin
                s_d = s_q + STG_ONE;
                k_d = '0;
            end
            default: ;
        endcase
    end

    assign rda_d = bf_addr_a(s_d, k_d);
    assign rdb_d = rda_d + (ONE << s_d);
    assign tw_d  = bf_tw(s_tot_q, s_d, k_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_tot_q <= '0;
            n_q     <= '0;
            s_q     <= '0;
            k_q     <= '0;
            dcnt_q  <= '0;
            rd_en_q <= 1'b0;
            rda_q   <= '0;
            rdb_q   <= '0;
            tw_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        s_tot_q <= stage_number;
                        n_q     <= max_point_fft;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (cfg_ok) begin
                        s_q     <= s_d;
                        k_q     <= k_d;
                        rd_en_q <= 1'b1;
                        rda_q   <= rda_d;
                        rdb_q   <= rdb_d;
                        tw_q    <= tw_d;
                        state_q <= ISSUE;
                    end else begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                ISSUE: begin
                    if (!hold) begin
                        if (k_q == last_k) begin
                            rd_en_q <= 1'b0;
                            dcnt_q  <= DRAIN_LAST;
                            state_q <= DRAIN;
                        end else begin
                            k_q   <= k_d;
                            rda_q <= rda_d;
                            rdb_q <= rdb_d;
                            tw_q  <= tw_d;
                        end
                    end
                end
                DRAIN: begin
                    // Next stage may only read once the last write of this stage has landed.
                    if (dcnt_q == 3'd0) begin
                        if (s_d != s_tot_q) begin
                            s_q     <= s_d;
                            k_q     <= k_d;
                            rd_en_q <= 1'b1;
                            rda_q   <= rda_d;
                            rdb_q   <= rdb_d;
                            tw_q    <= tw_d;
                            state_q <= ISSUE;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end
                    end else begin
                        dcnt_q <= dcnt_q - 3'd1;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    s_q     <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write-back shift pipeline, BF_LAT deep, keeps moving even while reads are stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BF_LAT; i++) begin
                vld_p[i] <= 1'b0;
                wra_p[i] <= '0;
                wrb_p[i] <= '0;
            end
        end else begin
            vld_p[0] <= rd_fire;
            wra_p[0] <= rda_q;
            wrb_p[0] <= rdb_q;
            for (int i = 1; i < BF_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                wra_p[i] <= wra_p[i-1];
                wrb_p[i] <= wrb_p[i-1];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cur_stage = s_q;
    assign rd_en     = rd_fire;
    assign rd_addr_a = rda_q;
    assign rd_addr_b = rdb_q;
    assign tw_addr   = tw_q;
    assign wr_en     = vld_p[BF_LAT-1];
    assign wr_addr_a = wra_p[BF_LAT-1];
    assign wr_addr_b = wrb_p[BF_LAT-1];

endmodule
